// File: rtl/lifo_selftest_pkg.sv
// Shared definitions for the LIFO self-test sequencer: state encoding and
// the fixed data constants used while exercising the stack.
package lifo_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_OVER,
    ST_CHKFULL,
    ST_DRAIN,
    ST_TAIL,
    ST_CHKEMPTY,
    ST_DONE
  } state_t;

  localparam logic [7:0] PATTERN_SEED   = 8'hA5;
  localparam logic [7:0] OVERFLOW_VALUE = 8'hFF;

endpackage

// File: rtl/lifo_selftest_if.sv
// Control/status bundle between the board top level (master) and the
// self-test sequencer (slave).
interface lifo_selftest_if;
  logic i_run;
  logic i_inject;
  logic o_running;
  logic o_passed;

  modport master (output i_run, output i_inject, input o_running, input o_passed);
  modport slave  (input i_run, input i_inject, output o_running, output o_passed);
endinterface

// File: rtl/lifo_selftest_lifo.sv
// Stack of DEPTH words with a registered read port. Push on full and pop on
// empty are silently dropped; push wins if both are requested.
module lifo #(
  parameter int DATA_SZ = 8,
  parameter int DEPTH   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [DATA_SZ-1:0] i_data,
  output logic [DATA_SZ-1:0] o_data,
  output logic               o_empty,
  output logic               o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_SZ-1:0] mem [DEPTH];
  logic [CW-1:0]      count_reg;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      top_idx;
  logic               do_push;
  logic               do_pop;

  assign o_empty = (count_reg == '0);
  assign o_full  = (count_reg == CW'(DEPTH));
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty && !i_push;
  assign wr_idx  = AW'(count_reg);
  assign top_idx = AW'(count_reg - 1'b1);

  // Storage carries no reset so it can map onto RAM; occupancy alone defines validity.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_idx] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_reg <= '0;
      o_data    <= '0;
    end else if (do_push) begin
      count_reg <= count_reg + 1'b1;
    end else if (do_pop) begin
      o_data    <= mem[top_idx];
      count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/lifo_selftest.sv
// Self-test sequencer: fills the LIFO with a known pattern, probes overflow,
// drains and compares in reverse order, then holds a pass/fail verdict.
module lifo_selftest
  import lifo_selftest_pkg::*;
#(
  parameter int DATA_SZ = 8,
  parameter int DEPTH   = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  lifo_selftest_if.slave  bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  state_t             state_reg, state_next;
  logic [CW-1:0]      idx_reg, idx_next;
  logic               err_reg, err_next;
  logic               inject_reg, inject_next;
  logic               passed_reg, passed_next;
  logic               cmp_valid_reg, cmp_valid_next;
  logic [DATA_SZ-1:0] exp_reg, exp_next;

  logic               push;
  logic               pop;
  logic [DATA_SZ-1:0] push_data;
  logic [DATA_SZ-1:0] pop_data;
  logic               lifo_empty;
  logic               lifo_full;
  logic               check_fail;

  function automatic logic [DATA_SZ-1:0] pattern(input logic [CW-1:0] i);
    return DATA_SZ'(PATTERN_SEED) ^ DATA_SZ'(i);
  endfunction

  lifo #(.DATA_SZ(DATA_SZ), .DEPTH(DEPTH)) u_lifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_pop  (pop),
    .i_data (push_data),
    .o_data (pop_data),
    .o_empty(lifo_empty),
    .o_full (lifo_full)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      err_reg       <= 1'b0;
      inject_reg    <= 1'b0;
      passed_reg    <= 1'b0;
      cmp_valid_reg <= 1'b0;
      exp_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      err_reg       <= err_next;
      inject_reg    <= inject_next;
      passed_reg    <= passed_next;
      cmp_valid_reg <= cmp_valid_next;
      exp_reg       <= exp_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    err_next       = err_reg;
    inject_next    = inject_reg;
    passed_next    = passed_reg;
    cmp_valid_next = 1'b0;
    exp_next       = exp_reg;
    push           = 1'b0;
    pop            = 1'b0;
    push_data      = pattern(idx_reg);
    check_fail     = 1'b0;

    // Popped word lands one cycle after the pop; compare it against the value queued then.
    if (cmp_valid_reg && (pop_data != exp_reg)) begin
      err_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.i_run) begin
          inject_next = bus.i_inject;
          err_next    = 1'b0;
          idx_next    = '0;
          state_next  = ST_FILL;
        end
      end
      ST_FILL: begin
        push      = 1'b1;
        push_data = pattern(idx_reg) ^ DATA_SZ'(inject_reg && (idx_reg == '0));
        idx_next  = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          idx_next   = '0;
          state_next = ST_OVER;
        end
      end
      ST_OVER: begin
        push       = 1'b1;
        push_data  = DATA_SZ'(OVERFLOW_VALUE);
        state_next = ST_CHKFULL;
      end
      ST_CHKFULL: begin
        if (!lifo_full || lifo_empty) begin
          err_next = 1'b1;
        end
        idx_next   = '0;
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        pop            = 1'b1;
        cmp_valid_next = 1'b1;
        exp_next       = pattern(LAST_IDX - idx_reg);
        idx_next       = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = ST_TAIL;
        end
      end
      ST_TAIL: begin
        state_next = ST_CHKEMPTY;
      end
      ST_CHKEMPTY: begin
        check_fail  = !lifo_empty || lifo_full;
        err_next    = err_reg || check_fail;
        passed_next = !(err_reg || check_fail);
        state_next  = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.i_run) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.o_running = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign bus.o_passed  = passed_reg;

endmodule

// File: tb/tb_lifo_selftest.sv
// Drives two self-test instances (16x8 and 2x4) through directed and random
// passes, checking run length, popped words, flags and verdict against a stack model.
module tb_lifo_selftest;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lifo_selftest_if if16();
  lifo_selftest_if if2();

  lifo_selftest #(.DATA_SZ(8), .DEPTH(16)) dut16 (.i_clk(clk), .i_rst(rst), .bus(if16));
  lifo_selftest #(.DATA_SZ(4), .DEPTH(2))  dut2  (.i_clk(clk), .i_rst(rst), .bus(if2));

  logic [1:0] running_w, passed_w, full_w, empty_w;
  logic [7:0] data16, data2;
  assign running_w = {if2.o_running, if16.o_running};
  assign passed_w  = {if2.o_passed, if16.o_passed};
  assign full_w    = {dut2.u_lifo.o_full, dut16.u_lifo.o_full};
  assign empty_w   = {dut2.u_lifo.o_empty, dut16.u_lifo.o_empty};
  assign data16    = dut16.u_lifo.o_data;
  assign data2     = {4'b0000, dut2.u_lifo.o_data};

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_words [16];
  logic       exp_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic run, input logic inj);
    if (w == 0) begin
      if16.i_run = run; if16.i_inject = inj;
    end else begin
      if2.i_run = run; if2.i_inject = inj;
    end
  endtask

  // Stack model: push the pattern, attempt the overflow push, pop everything.
  task automatic build_model(input int depth, input int dsz, input bit inj);
    logic [7:0] stack [$];
    int mask = (1 << dsz) - 1;
    for (int i = 0; i < depth; i++) begin
      int v = (8'hA5 ^ i) & mask;
      if (inj && i == 0) v = v ^ 1;
      stack.push_back(8'(v));
    end
    if (stack.size() < depth) stack.push_back(8'(8'hFF & mask));
    exp_pass = 1'b1;
    for (int j = 0; j < depth; j++) begin
      exp_words[j] = stack.pop_back();
      if (exp_words[j] != 8'((8'hA5 ^ (depth - 1 - j)) & mask)) exp_pass = 1'b0;
    end
  endtask

  task automatic do_pass(input int w, input bit inj, input int drop_at);
    int   depth = (w == 0) ? 16 : 2;
    int   dsz   = (w == 0) ? 8 : 4;
    int   c;
    logic prev;
    logic [7:0] word;
    build_model(depth, dsz, inj);
    prev = passed_w[w];
    drive(w, 1'b1, inj);
    @(negedge clk);
    chk("start", 32'(running_w[w]), 32'd1);
    c = 0;
    while (running_w[w] && c < 2 * depth + 10) begin
      chk("hold_passed", 32'(passed_w[w]), 32'(prev));
      if (c == depth || c == depth + 1) chk("full_over", 32'(full_w[w]), 32'd1);
      if (c == depth + 1) chk("not_empty_full", 32'(empty_w[w]), 32'd0);
      if (c >= depth + 3 && c <= 2 * depth + 2) begin
        word = (w == 0) ? data16 : data2;
        chk($sformatf("pop%0d", c - depth - 3), 32'(word), 32'(exp_words[c - depth - 3]));
      end
      if (c == 2 * depth + 3) begin
        chk("empty_end", 32'(empty_w[w]), 32'd1);
        chk("not_full_end", 32'(full_w[w]), 32'd0);
      end
      if (c == drop_at) drive(w, 1'b0, inj);
      c++;
      @(negedge clk);
    end
    chk("run_len", 32'(c), 32'(2 * depth + 4));
    chk("verdict", 32'(passed_w[w]), 32'(exp_pass));
    $display("pass dut%0d depth=%0d inject=%0d drop_at=%0d cycles=%0d passed=%0b expected=%0b",
             w, depth, inj, drop_at, c, passed_w[w], exp_pass);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_running", 32'(running_w[w]), 32'd0);
      chk("rst_passed", 32'(passed_w[w]), 32'd0);
      chk("rst_empty", 32'(empty_w[w]), 32'd1);
      chk("rst_full", 32'(full_w[w]), 32'd0);
    end
    $display("reset checked");
    rst = 1'b0;
    @(negedge clk);

    // Clean pass on the 16-deep instance.
    do_pass(0, 1'b0, -1);
    drive(0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset ten cycles into a pass must clear everything without a clock edge.
    drive(0, 1'b1, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_running", 32'(running_w[0]), 32'd0);
    chk("midrst_passed", 32'(passed_w[0]), 32'd0);
    chk("midrst_empty", 32'(empty_w[0]), 32'd1);
    $display("mid-pass reset checked");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    @(negedge clk);
    do_pass(0, 1'b0, -1);
    drive(0, 1'b0, 1'b0);
    @(negedge clk);

    // Injected fault, then run held high: no restart until it drops.
    do_pass(0, 1'b1, -1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_restart", 32'(running_w[0]), 32'd0);
    end
    chk("verdict_held", 32'(passed_w[0]), 32'd0);
    $display("no-restart hold checked");
    drive(0, 1'b0, 1'b0);
    @(negedge clk);
    do_pass(0, 1'b0, -1);
    drive(0, 1'b0, 1'b0);
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      do_pass(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)));
      drive(0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Minimum-size instance.
    do_pass(1, 1'b0, -1);
    drive(1, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      do_pass(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 10)));
      drive(1, 1'b0, 1'b0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
